cpm_cfg_arb: RTL and testbench
==============================

CPM_CFG_ARB -- requirements
Module: CPM_CFG_ARB

Interface
REQ-001 SHALL have parameter DW, default 8: width of one configuration entry.
REQ-002 SHALL have parameter CLR_VAL, default 0: reserved; the sweep clear value is supplied by ClrData.
REQ-003 SHALL have port Clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port ReqVld  input  4: request valid, bit i = requester i.
REQ-006 SHALL have port ReqWr  input  4: bit i, 1 = write, 0 = read.
REQ-007 SHALL have port ReqAddr  input  16: requester i entry address at [4i+3:4i].
REQ-008 SHALL have port ReqData  input  4*DW: requester i write data at [DW*i+DW-1:DW*i].
REQ-009 SHALL have port ReqAck  output  4: one-hot, single-cycle acknowledge.
REQ-010 SHALL have port RspVld  output  1: read response valid, one-cycle pulse.
REQ-011 SHALL have port RspId  output  2: requester index of the read response.
REQ-012 SHALL have port RspData  output  DW: read data.
REQ-013 SHALL have port ClrReq  input  1: request a full-array clear sweep.
REQ-014 SHALL have port ClrData  input  DW: value written to every entry during the sweep.
REQ-015 SHALL have port ClrBusy  output  1: high while the sweep runs.
REQ-016 SHALL have port CfgOut  output  16*DW: entry k at [DW*k+DW-1:DW*k], driving the datapath.

Function
REQ-017 SHALL hold a 16-entry x DW register array; each entry is written by the controller only, one entry per cycle at most.
REQ-018 SHALL implement FSM states IDLE, XFER, CLR.
REQ-019 IDLE: if the clear-pending flag is set, SHALL go to CLR; else if ReqVld is nonzero, SHALL go to XFER; else stay in IDLE.
REQ-020 Clear SHALL take priority over all requests in IDLE.
REQ-021 Arbitration SHALL be round-robin: search starts at index (Ptr+1) mod 4 and the first set ReqVld bit wins.
REQ-022 On IDLE->XFER, SHALL latch winner id, ReqWr, ReqAddr and ReqData of the winner.
REQ-023 XFER: ReqAck[id] SHALL be high for exactly this cycle.
REQ-024 XFER write: the entry at the latched address SHALL take the latched data at the end of the XFER cycle, visible on CfgOut the next cycle.
REQ-025 XFER read: the array entry SHALL be registered into RspData, with RspVld=1 and RspId=id in the cycle after XFER.
REQ-026 XFER SHALL set Ptr to id and always return to IDLE; throughput is one access per 2 cycles; IDLE request to ack latency is 1 cycle.
REQ-027 A requester SHALL hold ReqVld and its fields until ack.
REQ-028 If the winner drops ReqVld after being latched, the latched access SHALL still complete and be acked.
REQ-029 ClrReq SHALL be sampled in every state and set a pending flag; the flag SHALL clear on entry to CLR.
REQ-030 A ClrReq arriving during CLR SHALL set the flag again, causing one further sweep.
REQ-031 CLR: a 4-bit counter starting at 0 SHALL write ClrData to entry cnt each cycle, for 16 cycles.
REQ-032 CLR SHALL go to IDLE after entry 15 is written.
REQ-033 ClrBusy SHALL equal (state==CLR).
REQ-034 During CLR, no ReqAck SHALL be issued; requests wait.
REQ-035 ReqAck, RspVld and ClrBusy SHALL be registered outputs, glitch-free.
REQ-036 Two requests to the same entry SHALL be serialized in grant order: the later write wins, and a read returns the value committed before it.

Reset
REQ-037 On Rstn=0, asynchronously: state=IDLE; all 16 entries=0; Ptr=3, so requester 0 has priority first; clear flag=0; cnt=0; ReqAck=0; RspVld=0; RspId=0; RspData=0; ClrBusy=0.
REQ-038 Reset asserted mid-XFER or mid-CLR SHALL abort the operation with no ack and no response; the array is fully zeroed.
REQ-039 The first possible grant SHALL occur 1 cycle after Rstn rises.

Verification
REQ-040 Write then read: requester 2 writes 0xA5 to addr 7; CfgOut[63:56]=0xA5 one cycle after ack; requester 2 reads addr 7; RspVld with RspId=2, RspData=0xA5 the cycle after its ack.
REQ-041 Fairness: all four ReqVld held high continuously from reset; acks appear in order 0,1,2,3,0,… every 2 cycles.
REQ-042 Clear priority: ClrReq pulses while requester 1 is in XFER; the access completes, then ClrBusy is high for exactly 16 cycles with ClrData=0x3C; all 16 entries read 0x3C; the pending request 1 is acked 1 cycle after ClrBusy falls.
REQ-043 Double clear: ClrReq pulses during CLR at cnt=5; two back-to-back sweeps (32 ClrBusy cycles) are observed.
REQ-044 Reset mid-CLR: Rstn low at cnt=8; all CfgOut=0, ClrBusy=0; after release, requester 0 wins a simultaneous 0+3 request.
REQ-045 Dropped request: requester 3 deasserts ReqVld in its XFER cycle; the latched write still commits and ReqAck[3] pulses once.

Source files
------------

// File: rtl/cpm_cfg_arb.sv
// ---------------------------------------------------------------------------
// cpm_cfg_arb
//
// Four-requester round-robin arbiter in front of a 16-entry configuration
// register array. One access is serviced every two cycles (IDLE grant, XFER
// commit). A clear request runs a 16-cycle sweep that writes ClrData to
// every entry; a pending clear outranks all requests. The whole array is
// exposed continuously on CfgOut to drive the datapath.
//
// Ports
//   Clk      in   clock, rising-edge active
//   Rstn     in   asynchronous active-low reset
//   ReqVld   in   [3:0]     request valid, bit i = requester i
//   ReqWr    in   [3:0]     1 = write, 0 = read, per requester
//   ReqAddr  in   [15:0]    requester i entry address at [4i+3:4i]
//   ReqData  in   [4*DW-1:0] requester i write data at [DW*i +: DW]
//   ReqAck   out  [3:0]     one-hot single-cycle acknowledge (registered)
//   RspVld   out            read response valid pulse (registered)
//   RspId    out  [1:0]     requester index of the read response
//   RspData  out  [DW-1:0]  read data
//   ClrReq   in             request a full-array clear sweep
//   ClrData  in   [DW-1:0]  value written to every entry by the sweep
//   ClrBusy  out            high while the sweep runs (registered)
//   CfgOut   out  [16*DW-1:0] entry k at [DW*k +: DW]
// ---------------------------------------------------------------------------
module cpm_cfg_arb #(
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic              Clk,
    input  logic              Rstn,
    input  logic [3:0]        ReqVld,
    input  logic [3:0]        ReqWr,
    input  logic [15:0]       ReqAddr,
    input  logic [4*DW-1:0]   ReqData,
    output logic [3:0]        ReqAck,
    output logic              RspVld,
    output logic [1:0]        RspId,
    output logic [DW-1:0]     RspData,
    input  logic              ClrReq,
    input  logic [DW-1:0]     ClrData,
    output logic              ClrBusy,
    output logic [16*DW-1:0]  CfgOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CLR  = 2'd2
    } state_e;

    // CLR_VAL is reserved; the sweep value always comes from ClrData.
    logic unused_clr_val;
    assign unused_clr_val = ^CLR_VAL;

    state_e         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic           clr_pend_q, clr_pend_d;
    logic [3:0]     cnt_q, cnt_d;

    // Access captured at grant time; the requester may drop its request
    // after the grant and the access still completes from these copies.
    logic [1:0]     id_q, id_d;
    logic           wr_q, wr_d;
    logic [3:0]     addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;

    logic [3:0]     ack_q, ack_d;
    logic           rsp_vld_q, rsp_vld_d;
    logic [1:0]     rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           clr_busy_q, clr_busy_d;

    logic [DW-1:0]  cfg_q [16];

    // Single array write port shared by XFER writes and the clear sweep.
    logic           we;
    logic [3:0]     waddr;
    logic [DW-1:0]  wdata;

    logic [1:0]     win;

    // Round-robin pick: offsets 1..4 from ptr, lowest offset with a set
    // valid bit wins. Iterating from the farthest offset down lets the
    // nearest one overwrite the result.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [3:0] vld);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (vld[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign win = rr_pick(ptr_q, ReqVld);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_pend_d = clr_pend_q | ClrReq;
        cnt_d      = cnt_q;
        id_d       = id_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ack_d      = '0;
        rsp_vld_d  = 1'b0;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        we         = 1'b0;
        waddr      = addr_q;
        wdata      = data_q;

        unique case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    // Entering the sweep consumes the pending clear.
                    state_d    = CLR;
                    clr_pend_d = 1'b0;
                    cnt_d      = '0;
                end else if (|ReqVld) begin
                    state_d    = XFER;
                    id_d       = win;
                    wr_d       = ReqWr[win];
                    addr_d     = ReqAddr[{win, 2'b00} +: 4];
                    data_d     = ReqData[DW*win +: DW];
                    ack_d[win] = 1'b1;
                end
            end

            XFER: begin
                state_d = IDLE;
                ptr_d   = id_q;
                if (wr_q) begin
                    we = 1'b1;
                end else begin
                    rsp_vld_d  = 1'b1;
                    rsp_id_d   = id_q;
                    rsp_data_d = cfg_q[addr_q];
                end
            end

            CLR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = ClrData;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        clr_busy_d = (state_d == CLR);
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            clr_pend_q <= 1'b0;
            cnt_q      <= '0;
            id_q       <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ack_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_pend_q <= clr_pend_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // NOTE: the array is reset in full because it drives the datapath
    // directly; it is a flop bank, not a RAM macro, so this is legal.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            for (int k = 0; k < 16; k++) cfg_q[k] <= '0;
        end else if (we) begin
            cfg_q[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_cfg_out
        assign CfgOut[DW*k +: DW] = cfg_q[k];
    end

    assign ReqAck  = ack_q;
    assign RspVld  = rsp_vld_q;
    assign RspId   = rsp_id_q;
    assign RspData = rsp_data_q;
    assign ClrBusy = clr_busy_q;

endmodule

// File: tb/tb_cpm_cfg_arb.sv
// ---------------------------------------------------------------------------
// tb_cpm_cfg_arb
//
// Self-checking bench for cpm_cfg_arb. A reference copy of the array tracks
// every granted write and sweep; each granted read pushes its expected
// response onto a queue that a monitor pops whenever RspVld is seen.
// ---------------------------------------------------------------------------
module tb_cpm_cfg_arb;

    localparam int DW = 8;

    logic              Clk;
    logic              Rstn;
    logic [3:0]        ReqVld;
    logic [3:0]        ReqWr;
    logic [15:0]       ReqAddr;
    logic [4*DW-1:0]   ReqData;
    logic [3:0]        ReqAck;
    logic              RspVld;
    logic [1:0]        RspId;
    logic [DW-1:0]     RspData;
    logic              ClrReq;
    logic [DW-1:0]     ClrData;
    logic              ClrBusy;
    logic [16*DW-1:0]  CfgOut;

    cpm_cfg_arb #(.DW(DW)) dut (
        .Clk     (Clk),
        .Rstn    (Rstn),
        .ReqVld  (ReqVld),
        .ReqWr   (ReqWr),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .ReqAck  (ReqAck),
        .RspVld  (RspVld),
        .RspId   (RspId),
        .RspData (RspData),
        .ClrReq  (ClrReq),
        .ClrData (ClrData),
        .ClrBusy (ClrBusy),
        .CfgOut  (CfgOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]   model [16];
    logic [DW+1:0]   rsp_q [$];    // {id, data}

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag);
        logic [16*DW-1:0] exp;
        for (int k = 0; k < 16; k++) exp[DW*k +: DW] = model[k];
        check(tag, CfgOut, exp);
    endtask

    task automatic model_fill(input logic [DW-1:0] v);
        for (int k = 0; k < 16; k++) model[k] = v;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rstn = 1'b0;
        model_fill('0);
        rsp_q.delete();
        repeat (2) @(negedge Clk);
        Rstn = 1'b1;
    endtask

    task automatic drive_req(input int id, input logic wr,
                             input logic [3:0] addr, input logic [DW-1:0] data);
        ReqVld[id]          = 1'b1;
        ReqWr[id]           = wr;
        ReqAddr[4*id +: 4]  = addr;
        ReqData[DW*id +: DW] = data;
    endtask

    // Issue one request and wait (bounded) for its ack; returns in the XFER
    // cycle with the number of cycles from drive to ack.
    task automatic do_req(input int id, input logic wr, input logic [3:0] addr,
                          input logic [DW-1:0] data, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        drive_req(id, wr, addr, data);
        while (!got && lat < 100) begin
            @(negedge Clk);
            lat++;
            if (ReqAck[id]) got = 1'b1;
        end
        check($sformatf("ack_seen_r%0d", id), got, 1'b1);
        ReqVld[id] = 1'b0;
        if (got) begin
            if (wr) model[addr] = data;
            else    rsp_q.push_back({2'(id), model[addr]});
        end
    endtask

    // Response scoreboard and ack sanity, sampled on the falling edge.
    always @(negedge Clk) begin
        if (Rstn) begin
            if (ReqAck != 4'd0) check("ack_onehot", $onehot(ReqAck), 1'b1);
            if (RspVld) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", RspVld, 1'b0);
                end else begin
                    logic [DW+1:0] e;
                    e = rsp_q.pop_front();
                    check("rsp_id", RspId, e[DW+1:DW]);
                    check("rsp_data", RspData, e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int busy;
        int rises;
        int acks;
        logic prev_busy;

        Rstn    = 1'b0;
        ReqVld  = '0;
        ReqWr   = '0;
        ReqAddr = '0;
        ReqData = '0;
        ClrReq  = 1'b0;
        ClrData = '0;
        model_fill('0);

        // Reset values
        #1;
        check("rst_ack", ReqAck, 4'd0);
        check("rst_rspvld", RspVld, 1'b0);
        check("rst_rspid", RspId, 2'd0);
        check("rst_rspdata", RspData, 8'd0);
        check("rst_clrbusy", ClrBusy, 1'b0);
        check_cfg("rst_cfg");
        apply_reset();

        // Write then read through requester 2
        do_req(2, 1'b1, 4'd7, 8'hA5, lat);
        check("grant_latency", lat, 1);
        @(negedge Clk);
        check("cfg_entry7", CfgOut[63:56], 8'hA5);
        do_req(2, 1'b0, 4'd7, 8'h00, lat);
        repeat (2) @(negedge Clk);
        check("rsp_drained_1", rsp_q.size(), 0);

        // Same-entry serialisation: later write wins, read sees it
        do_req(0, 1'b1, 4'd5, 8'h11, lat);
        do_req(1, 1'b1, 4'd5, 8'h22, lat);
        do_req(3, 1'b0, 4'd5, 8'h00, lat);
        do_req(0, 1'b0, 4'd7, 8'h00, lat);
        repeat (2) @(negedge Clk);
        check_cfg("cfg_after_serial");

        // Fairness: all four held from reset
        for (int i = 0; i < 4; i++) drive_req(i, 1'b1, 4'(i), 8'(8'h10 + i));
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (i % 2 == 1) check($sformatf("rr_ack_%0d", i), ReqAck,
                                  4'b0001 << (((i - 1) / 2) % 4));
            else            check($sformatf("rr_gap_%0d", i), ReqAck, 4'd0);
        end
        ReqVld = '0;
        for (int i = 0; i < 4; i++) model[i] = 8'(8'h10 + i);
        @(negedge Clk);
        check_cfg("cfg_after_rr");

        // Clear priority: pulse during requester 1 XFER, second r1 request waits
        ClrData = 8'h3C;
        do_req(1, 1'b1, 4'd3, 8'h77, lat);
        ClrReq = 1'b1;
        drive_req(1, 1'b1, 4'd4, 8'h55);
        @(negedge Clk);
        ClrReq = 1'b0;
        check("xfer_done_before_clr", CfgOut[31:24], 8'h77);
        check("no_busy_yet", ClrBusy, 1'b0);
        lat = 0;
        while (!ClrBusy && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
        busy = 0;
        acks = 0;
        while (ClrBusy && busy < 40) begin
            busy++;
            if (ReqAck != 4'd0) acks++;
            @(negedge Clk);
        end
        check("clr_busy_len", busy, 16);
        check("no_ack_in_clr", acks, 0);
        model_fill(8'h3C);
        check_cfg("cfg_after_clr");
        check("ack_wait_idle", ReqAck, 4'd0);
        @(negedge Clk);
        check("ack_after_clr", ReqAck, 4'b0010);
        ReqVld[1] = 1'b0;
        model[4] = 8'h55;
        @(negedge Clk);
        check_cfg("cfg_after_pending");

        // Double clear: re-request at cnt=5
        ClrData = 8'h5A;
        ClrReq  = 1'b1;
        busy = 0;
        rises = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            ClrReq = 1'b0;
            if (ClrBusy) begin
                if (busy == 5) ClrReq = 1'b1;
                busy++;
                if (!prev_busy) rises++;
            end
            prev_busy = ClrBusy;
        end
        check("dbl_clr_cycles", busy, 32);
        check("dbl_clr_sweeps", rises, 2);
        model_fill(8'h5A);
        check_cfg("cfg_after_dbl");

        // Reset mid-sweep at cnt=8, then 0 beats 3
        ClrData = 8'h11;
        ClrReq  = 1'b1;
        @(negedge Clk);
        ClrReq = 1'b0;
        lat = 0;
        while (!ClrBusy && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
        repeat (8) @(negedge Clk);
        Rstn = 1'b0;
        #1;
        model_fill('0);
        rsp_q.delete();
        check_cfg("cfg_rst_mid_clr");
        check("busy_rst_mid_clr", ClrBusy, 1'b0);
        drive_req(0, 1'b1, 4'd0, 8'hEE);
        drive_req(3, 1'b1, 4'd1, 8'hDD);
        @(negedge Clk);
        Rstn = 1'b1;
        @(negedge Clk);
        check("first_grant_r0", ReqAck, 4'b0001);
        ReqVld[0] = 1'b0;
        model[0] = 8'hEE;
        repeat (2) @(negedge Clk);
        check("then_grant_r3", ReqAck, 4'b1000);
        ReqVld[3] = 1'b0;
        model[1] = 8'hDD;
        @(negedge Clk);
        check_cfg("cfg_after_rst_grants");

        // Dropped request: requester 3 lets go inside its XFER cycle
        drive_req(3, 1'b1, 4'd9, 8'hC3);
        @(posedge Clk);
        #1;
        ReqVld[3] = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (ReqAck[3]) acks++;
        end
        check("drop_ack_once", acks, 1);
        model[9] = 8'hC3;
        check_cfg("cfg_after_drop");

        repeat (2) @(negedge Clk);
        check("rsp_drained_end", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
